// File: rtl/jpegls_stage_fifo_pipe_if.sv
// Handshake and payload bundle between JPEG-LS stage 3 (context/mode) and stage 4 (Golomb/run).
interface jpegls_stage_fifo_pipe_if #(
  parameter int unsigned pixel_length    = 8,
  parameter int unsigned mode_length     = 2,
  parameter int unsigned runcount_length = 16
);
  // upstream side
  logic                       in_valid;
  logic                       in_ready;
  logic [pixel_length-1:0]    x_in;
  logic [pixel_length-1:0]    Px_in;
  logic                       sign_in;
  logic                       RIType_in;
  logic                       EOF_in;
  logic [mode_length-1:0]     mode_in;
  logic [mode_length-1:0]     previous_mode_in;
  logic [mode_length-1:0]     mode_next_in;
  logic [runcount_length-1:0] run_length_in;
  logic [runcount_length-1:0] remainder_subtract_in;
  // downstream side
  logic                       out_valid;
  logic                       out_ready;
  logic [pixel_length-1:0]    x_out;
  logic [pixel_length-1:0]    Px_out;
  logic                       sign_out;
  logic                       RIType_out;
  logic                       EOF_out;
  logic [mode_length-1:0]     mode_out;
  logic [runcount_length-1:0] run_length_out;
  logic                       do_run_encoding_out;
  logic                       do_run_length_adjust_out;
  logic [runcount_length-1:0] remainder_accum_out;

  // environment view: produces upstream beats and downstream ready
  modport master (
    output in_valid, x_in, Px_in, sign_in, RIType_in, EOF_in, mode_in,
           previous_mode_in, mode_next_in, run_length_in, remainder_subtract_in,
           out_ready,
    input  in_ready, out_valid, x_out, Px_out, sign_out, RIType_out, EOF_out,
           mode_out, run_length_out, do_run_encoding_out, do_run_length_adjust_out,
           remainder_accum_out
  );

  // pipeline stage view
  modport slave (
    input  in_valid, x_in, Px_in, sign_in, RIType_in, EOF_in, mode_in,
           previous_mode_in, mode_next_in, run_length_in, remainder_subtract_in,
           out_ready,
    output in_ready, out_valid, x_out, Px_out, sign_out, RIType_out, EOF_out,
           mode_out, run_length_out, do_run_encoding_out, do_run_length_adjust_out,
           remainder_accum_out
  );
endinterface

// File: rtl/jpegls_stage_fifo_pipe.sv
// Elastic stage-3/stage-4 FIFO for the JPEG-LS encoder: computes run flags at the input,
// holds pixel-class fields across run samples and keeps a saturating remainder accumulator.
module jpegls_stage_fifo_pipe #(
  parameter int unsigned pixel_length    = 8,
  parameter int unsigned mode_length     = 2,
  parameter int unsigned runcount_length = 16,
  parameter int unsigned DEPTH           = 2
) (
  input logic clk,
  input logic reset,
  input logic flush,
  jpegls_stage_fifo_pipe_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [mode_length-1:0] MODE_REGULAR   = mode_length'(0);
  localparam logic [mode_length-1:0] MODE_RUN       = mode_length'(1);
  localparam logic [mode_length-1:0] MODE_INTERRUPT = mode_length'(2);

  typedef struct packed {
    logic [pixel_length-1:0]    x;
    logic [pixel_length-1:0]    px;
    logic                       sign;
    logic                       ri_type;
    logic                       eof;
    logic [mode_length-1:0]     mode;
    logic [runcount_length-1:0] run_length;
    logic                       run_enc;
    logic                       run_adj;
    logic [runcount_length-1:0] accum;
  } entry_t;

  entry_t                     mem [DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic [runcount_length-1:0] acc;
  logic [pixel_length-1:0]    held_x;
  logic [pixel_length-1:0]    held_px;
  logic                       held_sign;
  logic                       held_ri_type;

  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;
  logic                       pixel_class;
  logic [runcount_length:0]   sum_wide;
  logic [runcount_length-1:0] sum;
  entry_t                     new_entry;
  entry_t                     head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.in_valid && !full;
  assign pop   = !empty && bus.out_ready;

  // Regular and run-interruption samples carry fresh pixel fields; run samples reuse the held ones.
  assign pixel_class = (bus.mode_in == MODE_REGULAR) || (bus.mode_in == MODE_INTERRUPT);

  // Saturating accumulate of the incoming remainder subtraction.
  assign sum_wide = {1'b0, acc} + {1'b0, bus.remainder_subtract_in};
  assign sum      = sum_wide[runcount_length] ? '1 : sum_wide[runcount_length-1:0];

  // Assemble the entry written on a push.
  always_comb begin
    new_entry            = '0;
    new_entry.x          = pixel_class ? bus.x_in      : held_x;
    new_entry.px         = pixel_class ? bus.Px_in     : held_px;
    new_entry.sign       = pixel_class ? bus.sign_in   : held_sign;
    new_entry.ri_type    = pixel_class ? bus.RIType_in : held_ri_type;
    new_entry.eof        = bus.EOF_in;
    new_entry.mode       = bus.mode_in;
    new_entry.run_length = bus.run_length_in;
    new_entry.run_enc    = ((bus.mode_next_in == MODE_INTERRUPT) && (bus.mode_in == MODE_RUN)) ||
                           ((bus.mode_in == MODE_INTERRUPT) && (bus.previous_mode_in != MODE_RUN));
    new_entry.run_adj    = (bus.mode_next_in == MODE_INTERRUPT);
    new_entry.accum      = sum;
  end

  // FIFO storage, pointers, occupancy, accumulator and held pixel fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      acc          <= '0;
      held_x       <= '0;
      held_px      <= '0;
      held_sign    <= 1'b0;
      held_ri_type <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      acc          <= '0;
      held_x       <= '0;
      held_px      <= '0;
      held_sign    <= 1'b0;
      held_ri_type <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ptr_inc(wr_ptr);
        acc         <= (new_entry.run_enc || bus.EOF_in) ? '0 : sum;
        if (pixel_class) begin
          held_x       <= bus.x_in;
          held_px      <= bus.Px_in;
          held_sign    <= bus.sign_in;
          held_ri_type <= bus.RIType_in;
        end
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Head entry, forced to zero while the FIFO is empty.
  assign head = empty ? '0 : mem[rd_ptr];

  assign bus.in_ready                 = !full;
  assign bus.out_valid                = !empty;
  assign bus.x_out                    = head.x;
  assign bus.Px_out                   = head.px;
  assign bus.sign_out                 = head.sign;
  assign bus.RIType_out               = head.ri_type;
  assign bus.EOF_out                  = head.eof;
  assign bus.mode_out                 = head.mode;
  assign bus.run_length_out           = head.run_length;
  assign bus.do_run_encoding_out      = head.run_enc;
  assign bus.do_run_length_adjust_out = head.run_adj;
  assign bus.remainder_accum_out      = head.accum;

endmodule

// File: doc/jpegls_stage_fifo_pipe.md
# jpegls_stage_fifo_pipe

Parametrised elastic pipeline stage for the JPEG-LS encoder, between context/mode evaluation (stage 3) and the Golomb/run encoder (stage 4). It replaces the fixed enable-gated stage-3 register bank with a DEPTH-entry FIFO that uses a valid/ready handshake. It computes the run-encoding and run-length-adjust flags at the input. It holds pixel-class fields across run-mode samples and keeps a true saturating accumulator of run remainder subtractions.

## Interface
Parameters:
- pixel_length, 8, width of x and Px
- mode_length, 2, width of mode fields (0 regular, 1 run, 2 run interruption, 3 run continue)
- runcount_length, 16, width of run_length, remainder_subtract and accumulator
- DEPTH, 2, FIFO entries; legal values 2..8; pointers use clog2(DEPTH) bits

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous clear of FIFO, accumulator and held fields
- in_valid  in  1  upstream beat present
- in_ready  out  1  = !full; has no combinational dependence on out_ready
- x_in, Px_in  in  pixel_length  sample and prediction
- sign_in, RIType_in, EOF_in  in  1 each  per-sample flags
- mode_in  in  mode_length  mode of this sample
- previous_mode_in  in  mode_length  mode of the previous sample
- mode_next_in  in  mode_length  mode of the following sample (one stage upstream)
- run_length_in  in  runcount_length  run count
- remainder_subtract_in  in  runcount_length  per-sample remainder subtraction
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- x_out, Px_out, sign_out, RIType_out, EOF_out, mode_out, run_length_out  out  same widths as the inputs
- do_run_encoding_out, do_run_length_adjust_out  out  1 each  flags computed at the input
- remainder_accum_out  out  runcount_length  accumulator value stored with the entry

## Operation
- push = in_valid && in_ready; pop = out_valid && out_ready.
- Circular FIFO with write pointer, read pointer and a count in 0..DEPTH. Pointers wrap from DEPTH-1 to 0.
- Outputs present the head entry. While out_valid=0, all data outputs are 0.
- Pixel-class fields (x, Px, sign, RIType) are held for run-mode samples:
  - mode_in ∈ {0,2}: the entry stores the input values, and these values are copied into the held registers.
  - mode_in ∈ {1,3}: the entry stores the held-register values instead of the inputs.
- mode, run_length and EOF are always stored from the inputs.
- do_run_encoding is set when any of these holds:
  - mode_next_in==2 && mode_in==1
  - mode_in==2 && previous_mode_in ∈ {0,2,3}
- do_run_length_adjust = (mode_next_in==2).
- Accumulator, on each push:
  - sum = acc + remainder_subtract_in, saturating at 2^runcount_length−1.
  - The entry stores sum.
  - acc then becomes 0 if the entry's do_run_encoding==1 or EOF_in==1; otherwise acc becomes sum.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
  - When full, in_ready=0, so no push occurs even if a pop happens; in_ready returns to 1 the cycle after the pop.
- flush has priority over push and pop:
  - count, pointers, acc and the held registers go to 0.
  - Any input beat in the flush cycle is dropped, and nothing is popped.

## Timing
- Reset values (asynchronous):
  - out_valid=0, all data outputs 0, count=0, acc=0, held registers 0.
  - in_ready=1 as soon as reset deasserts.
- Latency: a beat pushed at edge k appears at the head (empty FIFO case) with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one beat per cycle with out_ready held at 1 and DEPTH≥2.
- After flush at edge k: out_valid=0 and in_ready=1 after edge k.
- Reset asserted mid-operation: contents are lost immediately, without waiting for a clock edge.
- Empty: out_valid=0 and pop is ignored. Full: in_ready=0.

## Test plan
- Reset then 4 regular-mode beats (x=10,20,30,40), out_ready=1 → outputs appear in order, one cycle after each push; out_valid never drops between beats.
- DEPTH=2, out_ready=0, 3 beats offered → in_ready=0 after 2 accepts. Raise out_ready for 1 cycle → x=10 popped, in_ready=1 next cycle, third beat accepted. Order is preserved.
- Beat mode=0 x=55, then mode=1 x=99, then mode=3 x=77 → the second and third entries output x_out=55 and the held Px; the entry with mode=1, mode_next=2 shows do_run_encoding_out=1 and do_run_length_adjust_out=1.
- remainder_subtract = 3, 4, 5 with do_run_encoding on the third beat → remainder_accum_out = 3, 7, 12; the next beat with remainder_subtract=2 outputs 2. With runcount_length=4, inputs 9 and 9 → 15 (saturated).
- mode=2 with previous_mode=0 → do_run_encoding_out=1; with previous_mode=1 → 0.
- FIFO holding 2 entries, then flush together with in_valid=1 → out_valid=0 next cycle, the input is dropped and the accumulator reads 0 on the next push. Repeat with reset asserted between clock edges → outputs clear without waiting for a clock edge.
